// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// byte-address to word-index conversion.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dm_state_e;

  // Word index of a 32-bit byte address; callers slice the low bits they need.
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin pick: on a tie the port not granted last wins,
// otherwise the single requester wins. gnt is the winning port id.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt
);

  always_comb begin
    gnt = req1;
    if (req0 && req1) gnt = ~last;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates a CPU data port and a DMA/IO port onto one external memory.
// Optional write tracing is compiled in with `define DM_ARB_TRACE_EN.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [31:0]       pc0,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output dm_state_e         state_dbg
);

  // Handshake: a port raises req with we/addr/wdata and holds them stable
  // until it sees ack (one cycle, err qualifying it); it may then drop req.
  dm_state_e         state, state_nxt;
  logic              last, port_q, err_q, gnt;
  logic              req_m0, req_m1, take;
  logic [31:0]       sel_addr, sel_wdata;
  logic              sel_we, sel_err;
  logic [ADDR_W-1:0] sel_word;
  logic [29-ADDR_W:0] sel_hi;

  assign state_dbg = state;

  // The port being answered in RESP still holds req; mask it to avoid a regrant.
  always_comb begin
    req_m0 = req0 && !(state == RESP && port_q == 1'b0);
    req_m1 = req1 && !(state == RESP && port_q == 1'b1);
  end

  rr_arb2 u_rr (
    .req0 (req_m0),
    .req1 (req_m1),
    .last (last),
    .gnt  (gnt)
  );

  always_comb begin
    sel_addr  = gnt ? addr1  : addr0;
    sel_wdata = gnt ? wdata1 : wdata0;
    sel_we    = gnt ? we1    : we0;
    {sel_hi, sel_word} = word_index(sel_addr);
    sel_err   = (sel_hi != '0) || (sel_addr[1:0] != 2'b00);
    take      = (state != ISSUE) && (req_m0 || req_m1);
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = take ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // mem_* are loaded on the grant edge so they are valid throughout ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= PRIO_RESET;
      port_q    <= 1'b0;
      err_q     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      mem_we <= 1'b0;
      if (take) begin
        last      <= gnt;
        port_q    <= gnt;
        err_q     <= sel_err;
        mem_addr  <= sel_word;
        mem_wdata <= sel_wdata;
        mem_we    <= sel_we && !sel_err;
      end
      if (state == ISSUE) begin
        rdata <= err_q ? '0 : mem_rdata;
        ack0  <= !port_q;
        ack1  <= port_q;
        err0  <= !port_q && err_q;
        err1  <= port_q && err_q;
      end
    end
  end

`ifdef DM_ARB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && state == ISSUE && mem_we)
      $display("%d@%h: *%h <= %h", $time, port_q ? 32'h0 : pc0,
               {mem_addr, 2'b00}, mem_wdata);
  end
`else
  logic unused_pc0;
  assign unused_pc0 = ^pc0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: drivers push expected responses, monitors
// on the falling edge pop and compare acks and memory writes.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [31:0]       addr0, addr1, wdata0, wdata1, pc0;
  logic              ack0, ack1, err0, err1;
  logic [31:0]       rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  dm_state_e         state_dbg;

  dm_arbiter #(.ADDR_W(ADDR_W), .PRIO_RESET(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .pc0(pc0),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int n_we     = 0;
  logic [33:0]        exp_q0[$];   // {check_rdata, err, rdata}
  logic [33:0]        exp_q1[$];
  logic [ADDR_W+31:0] exp_wr_q[$]; // {word, data}
  logic alt_chk = 1'b0, prev_valid = 1'b0, prev_port = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic score(input int p, input logic err, input logic [31:0] rd);
    logic [33:0] e;
    if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      n_assert++; n_fail++;
      $display("FAIL unexpected_ack%0d: got ack with err=%b rdata=%h, expected none", p, err, rd);
    end else begin
      e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("err%0d", p), {31'b0, err}, {31'b0, e[32]});
      if (e[33]) check($sformatf("rdata%0d", p), rd, e[31:0]);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (ack0 || ack1) check("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
      if (err0) check("err0_qual", {31'b0, ack0}, 32'd1);
      if (err1) check("err1_qual", {31'b0, ack1}, 32'd1);
      if (ack0) score(0, err0, rdata);
      if (ack1) score(1, err1, rdata);
      if (alt_chk && (ack0 || ack1)) begin
        if (prev_valid) check("alternate", {31'b0, ack1}, {31'b0, !prev_port});
        prev_port  = ack1;
        prev_valid = 1'b1;
      end
      if (mem_we) begin
        n_we++;
        check("we_in_issue", {30'b0, state_dbg}, {30'b0, ISSUE});
        if (exp_wr_q.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL unexpected_write: got word %h data %h, expected none", mem_addr, mem_wdata);
        end else begin
          logic [ADDR_W+31:0] w;
          w = exp_wr_q.pop_front();
          check("wr_word", {22'b0, mem_addr}, {22'b0, w[ADDR_W+31:32]});
          check("wr_data", mem_wdata, w[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after dropping req.
  task automatic access(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [33:0] exp, output int lat);
    logic done;
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; pc0 = 32'h400 + addr;
      exp_q0.push_back(exp);
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      exp_q1.push_back(exp);
    end
    lat = 0; done = 1'b0;
    while (!done && lat < 16) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if ((p == 0) ? ack0 : ack1) done = 1'b1;
    end
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL ack_timeout%0d: got no ack in %0d cycles, expected ack", p, lat);
    end
    check($sformatf("max_wait%0d", p), {31'b0, lat > 4}, 32'd0);
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int lat, lat0, lat1, base;

  initial begin
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; pc0 = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[5] = 32'h55AA55AA;
    mem[8] = 32'hCAFEF00D;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {30'b0, state_dbg}, {30'b0, IDLE});
    check("rst_acks", {28'b0, ack0, ack1, err0, err1}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // tie after reset: port 1 first, port 0 two cycles later
    fork
      access(0, 1'b0, 32'h14, 32'h0, {2'b10, 32'h55AA55AA}, lat0);
      access(1, 1'b0, 32'h20, 32'h0, {2'b10, 32'hCAFEF00D}, lat1);
    join
    check("tie_lat1", lat1, 32'd2);
    check("tie_lat0", lat0, 32'd4);

    // single read
    access(0, 1'b0, 32'h10, 32'h0, {2'b10, 32'hDEADBEEF}, lat);
    check("single_lat", lat, 32'd2);

    // write-through
    base = n_we;
    exp_wr_q.push_back({10'd8, 32'h12345678});
    access(1, 1'b1, 32'h20, 32'h12345678, {2'b00, 32'h0}, lat);
    access(0, 1'b0, 32'h20, 32'h0, {2'b10, 32'h12345678}, lat);
    check("wt_we_cycles", n_we - base, 32'd1);

    // out-of-range and misaligned accesses
    base = n_we;
    access(0, 1'b1, 32'h00001000, 32'hBAD0BAD0, {2'b11, 32'h0}, lat);
    access(1, 1'b0, 32'h22, 32'h0, {2'b11, 32'h0}, lat);
    check("err_no_we", n_we - base, 32'd0);
    check("err_mem0", mem[0], 32'd0);

    // reset during ISSUE of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hAAAA5555; pc0 = 32'h500;
    @(posedge clk); #1;
    check("abort_in_issue", {30'b0, state_dbg}, {30'b0, ISSUE});
    check("abort_we_pre", {31'b0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_we", {31'b0, mem_we}, 32'd0);
    check("abort_state", {30'b0, state_dbg}, {30'b0, IDLE});
    check("abort_ack", {31'b0, ack0}, 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_mem", mem[12], 32'd0);

    // fairness: both ports requesting back to back
    alt_chk = 1'b1; prev_valid = 1'b0;
    fork
      begin
        int la;
        for (int i = 0; i < 5; i++) access(0, 1'b0, 32'h10, 32'h0, {2'b10, 32'hDEADBEEF}, la);
      end
      begin
        int lb;
        for (int j = 0; j < 5; j++) access(1, 1'b0, 32'h20, 32'h0, {2'b10, 32'h12345678}, lb);
      end
    join
    alt_chk = 1'b0;

    repeat (4) @(negedge clk);
    check("q0_drained", exp_q0.size(), 32'd0);
    check("q1_drained", exp_q1.size(), 32'd0);
    check("wr_drained", exp_wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_assert++; n_fail++;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
